// File: rtl/sram_clear_pkg.sv
// Shared types for the SRAM clear/write front end.
package sram_clear_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/sram_clear_ctrl.sv
// Write-port owner for a non-resettable SRAM: sweeps the array to INIT_VALUE
// after reset or on flush, and otherwise forwards functional writes one cycle late.
module sram_clear_ctrl
    import sram_clear_pkg::*;
#(
    parameter int unsigned            SIZE           = 1024,
    parameter int unsigned            DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE     = '0,
    parameter bit                     CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_req,
    input  logic                      fn_wr_valid,
    output logic                      fn_wr_ready,
    input  logic [$clog2(SIZE)-1:0]   fn_wr_addr,
    input  logic [DATA_WIDTH-1:0]     fn_wr_data,
    output logic                      mem_wr_en,
    output logic [$clog2(SIZE)-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0]     mem_wr_data,
    output logic                      busy,
    output logic                      clear_done
);

    localparam int unsigned   AW       = $clog2(SIZE);
    localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);
    localparam state_t        RST_ST   = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t                  state_q, state_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic                    fn_vld_q, fn_vld_d;
    logic [AW-1:0]           fn_addr_q, fn_addr_d;
    logic [DATA_WIDTH-1:0]   fn_data_q, fn_data_d;
    logic                    done_q, done_d;
    logic                    is_idle;
    logic                    fn_accept;

    assign is_idle   = (state_q == ST_IDLE);
    // Flush has priority over a write offered in the same cycle.
    assign fn_accept = is_idle & fn_wr_valid & ~flush_req;

    // Control state; rst is synchronous and overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_ST;
            cnt_q    <= '0;
            fn_vld_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fn_vld_q <= fn_vld_d;
            done_q   <= done_d;
        end
    end

    // Forwarding payload carries no reset; it is qualified by fn_vld_q.
    always_ff @(posedge clk) begin
        fn_addr_q <= fn_addr_d;
        fn_data_q <= fn_data_d;
    end

    // Next-state: sweep ends on compare with the last index, never on wrap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fn_vld_d  = 1'b0;
        fn_addr_d = fn_addr_q;
        fn_data_d = fn_data_q;
        done_d    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                if (fn_accept) begin
                    fn_vld_d  = 1'b1;
                    fn_addr_d = fn_wr_addr;
                    fn_data_d = fn_wr_data;
                end
                if (flush_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Outputs derive from state; control strobes are masked while rst is high.
    assign fn_wr_ready = ~rst & is_idle & ~flush_req;
    assign busy        = ~rst & ~is_idle;
    assign clear_done  = ~rst & done_q;
    assign mem_wr_en   = ~rst & (is_idle ? fn_vld_q : 1'b1);
    assign mem_wr_addr = is_idle ? fn_addr_q : cnt_q;
    assign mem_wr_data = is_idle ? fn_data_q : INIT_VALUE;

endmodule
